guest_parking_exit: RTL and testbench
=====================================

// Module: guest_parking_exit
// PURPOSE
//  Exit-side controller for the guest parking zone; the counterpart of guest entry.
//  Owns the guest free-slot register (thermometer code, LSB-aligned: a 1 bit is one free slot).
//  - Entry side consumes slots via entry_take.
//  - This block returns a slot on each completed guest exit, driving the exit gate and a req/ack handshake.
//  - Sits between the exit ticket reader and the exit gate actuator.
// PARAMETERS
//  N_GUEST           8   number of guest slots (>=2); width of the free-slot register
//  GATE_OPEN_CYCLES  16  cycles the gate stays open waiting for vehicle_pass (>=2)
// PORTS
//  clk           in   1                     clock, rising edge
//  rst           in   1                     synchronous reset, active-high
//  exit_req      in   1                     guest exit request, level; held until exit_ack or exit_fail
//  vehicle_pass  in   1                     gate sensor pulse: vehicle cleared exit gate
//  entry_take    in   1                     1-cycle pulse from entry side: one slot consumed
//  exit_ack      out  1                     1-cycle pulse: exit completed, slot returned
//  exit_fail     out  1                     1-cycle pulse: exit refused (no guest inside) or gate timeout
//  gate_open     out  1                     exit gate open command
//  avail_therm   out  N_GUEST               free-slot thermometer code
//  avail_count   out  $clog2(N_GUEST+1)     popcount of avail_therm
//  guest_full    out  1                     avail_therm == 0
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state=IDLE, avail_therm = all ones, avail_count = N_GUEST,
//    guest_full=0, exit_ack=0, exit_fail=0, gate_open=0, timer=0. Reset mid-operation aborts
//    any exit, closes the gate at once, and returns no slot.
//  FSM states: IDLE, OPEN, HOLD. All outputs registered.
//  IDLE:
//    - exit_req=1 and avail_therm all ones (no guest inside) -> exit_fail=1 next cycle; go HOLD.
//    - exit_req=1 otherwise -> gate_open=1 next cycle, timer=0; go OPEN.
//  OPEN:
//    - gate_open=1; timer increments each cycle.
//    - vehicle_pass=1 -> slot returned, exit_ack=1, gate_open=0 next cycle; go HOLD.
//    - timer reaches GATE_OPEN_CYCLES-1 with no pass -> exit_fail=1, gate_open=0, no slot returned; go HOLD.
//    - If the pass arrives in the timeout cycle itself, the pass wins.
//  HOLD: one cycle; exit_req ignored (requester drops req after ack/fail); then IDLE.
//  Latency:
//    - exit_req in IDLE -> gate_open: 1 cycle.
//    - vehicle_pass -> exit_ack and register update: 1 cycle.
//  Slot arithmetic, applied in the same cycle:
//    - return: avail_therm <= {avail_therm[N_GUEST-2:0],1'b1}
//    - take:   avail_therm <= {1'b0,avail_therm[N_GUEST-1:1]}
//  Simultaneous return and take: register unchanged.
//  entry_take while guest_full: ignored (no underflow). Return while all ones cannot occur.
//  avail_count and guest_full track avail_therm combinationally from the register.
//  vehicle_pass outside OPEN is ignored.
// CONFIGURATION
//  GUEST_EXIT_LOG_EN defined (simulation only):
//    - on exit_ack: $display "Guest vehicle exited."
//    - on exit_fail: "Guest exit refused." and the time.
//  GUEST_EXIT_LOG_EN undefined: no display code compiled; ports and timing are identical.
// TESTING
//  1 Reset, N_GUEST=8: avail_therm=8'hFF, avail_count=8, guest_full=0, all pulses 0.
//  2 Three entry_take pulses, then exit_req and vehicle_pass 3 cycles after gate_open.
//    -> therm 8'h1F, then 8'h3F; exit_ack 1 cycle after pass; gate_open low.
//  3 exit_req with therm=8'hFF -> exit_fail pulse next cycle; gate_open never rises; therm unchanged.
//  4 exit_req, no vehicle_pass -> gate_open high exactly 16 cycles, then exit_fail; therm unchanged.
//  5 therm=8'h0F; entry_take in the same cycle as vehicle_pass -> next cycle therm still 8'h0F.
//    Then 4 takes -> guest_full=1; a 5th take -> still 8'h00.
//  6 rst asserted while in OPEN -> next cycle gate_open=0, state IDLE, therm=8'hFF.

Source files
------------

// File: rtl/guest_parking_exit.sv
// guest_parking_exit: guest-zone exit gate controller owning the free-slot thermometer register
// Optional simulation log of exits enabled by defining GUEST_EXIT_LOG_EN.
module guest_parking_exit #(
  parameter int N_GUEST = 8,
  parameter int GATE_OPEN_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         exit_req,
  input  logic                         vehicle_pass,
  input  logic                         entry_take,
  output logic                         exit_ack,
  output logic                         exit_fail,
  output logic                         gate_open,
  output logic [N_GUEST-1:0]           avail_therm,
  output logic [$clog2(N_GUEST+1)-1:0] avail_count,
  output logic                         guest_full
);
  localparam int CW = $clog2(N_GUEST+1);
  localparam int TW = $clog2(GATE_OPEN_CYCLES);
  typedef enum logic [1:0] {IDLE, OPEN, HOLD} state_t;
  state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic ack_n, fail_n, gate_n, ret;
  logic [N_GUEST-1:0] therm_n;
  always_comb begin
    state_n = state;
    timer_n = timer;
    ack_n = 1'b0;
    fail_n = 1'b0;
    gate_n = 1'b0;
    case (state)
      IDLE: if (exit_req) begin
        fail_n = &avail_therm;
        gate_n = ~&avail_therm;
        timer_n = '0;
        state_n = &avail_therm ? HOLD : OPEN;
      end
      OPEN: if (vehicle_pass) begin
        ack_n = 1'b1;
        state_n = HOLD;
      end else if (timer == TW'(GATE_OPEN_CYCLES-1)) begin
        fail_n = 1'b1;
        state_n = HOLD;
      end else begin
        gate_n = 1'b1;
        timer_n = timer + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  // a take on an empty register shifts zeros into zeros, so underflow is impossible
  assign ret = (state == OPEN) && vehicle_pass;
  assign therm_n = (ret == entry_take) ? avail_therm
                 : ret ? {avail_therm[N_GUEST-2:0], 1'b1}
                 : {1'b0, avail_therm[N_GUEST-1:1]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      exit_ack <= 1'b0;
      exit_fail <= 1'b0;
      gate_open <= 1'b0;
      avail_therm <= '1;
    end else begin
      state <= state_n;
      timer <= timer_n;
      exit_ack <= ack_n;
      exit_fail <= fail_n;
      gate_open <= gate_n;
      avail_therm <= therm_n;
    end
  end
  assign avail_count = CW'($countones(avail_therm));
  assign guest_full = ~|avail_therm;
`ifdef GUEST_EXIT_LOG_EN
  always @(posedge clk) begin
    if (exit_ack) $display("Guest vehicle exited.");
    if (exit_fail) $display("Guest exit refused. t=%0t", $time);
  end
`else
`endif
endmodule

// File: tb/tb_guest_parking_exit.sv
// tb_guest_parking_exit: directed and random checks of guest_parking_exit against a slot-count model
module tb_guest_parking_exit;
  localparam int N = 8;
  localparam int G = 16;
  logic clk = 1'b0, rst = 1'b0, exit_req = 1'b0, vehicle_pass = 1'b0, entry_take = 1'b0;
  logic exit_ack, exit_fail, gate_open, guest_full;
  logic [N-1:0] avail_therm;
  logic [3:0] avail_count;
  int n_chk = 0, n_pass = 0;
  int m_free, m_t;
  logic m_open, m_hold, m_ack, m_fail, m_valid = 1'b0;
  logic [N-1:0] exp_therm;
  guest_parking_exit #(.N_GUEST(N), .GATE_OPEN_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .exit_req(exit_req), .vehicle_pass(vehicle_pass),
    .entry_take(entry_take), .exit_ack(exit_ack), .exit_fail(exit_fail),
    .gate_open(gate_open), .avail_therm(avail_therm), .avail_count(avail_count),
    .guest_full(guest_full));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  // Model: guests inside = N - m_free; gate phase tracked as cycles spent open.
  wire m_idle = !m_open && !m_hold;
  wire m_ret = m_open && vehicle_pass;
  wire m_tout = m_open && !vehicle_pass && (m_t == G-1);
  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b1;
      m_free <= N;
      m_open <= 1'b0;
      m_hold <= 1'b0;
      m_t <= 0;
      m_ack <= 1'b0;
      m_fail <= 1'b0;
    end else begin
      m_ack <= m_ret;
      m_fail <= (m_idle && exit_req && m_free == N) || m_tout;
      m_open <= (m_idle && exit_req && m_free < N) || (m_open && !vehicle_pass && !m_tout);
      m_hold <= (m_idle && exit_req && m_free == N) || m_ret || m_tout;
      m_t <= m_open ? m_t + 1 : 0;
      if (m_ret && !entry_take) m_free <= m_free + 1;
      else if (!m_ret && entry_take && m_free > 0) m_free <= m_free - 1;
    end
  end
  assign exp_therm = N'((16'd1 << m_free) - 16'd1);
  always @(negedge clk) if (m_valid) begin
    chk("therm", 32'(avail_therm), 32'(exp_therm));
    chk("count", 32'(avail_count), 32'(m_free));
    chk("full", 32'(guest_full), 32'(m_free == 0));
    chk("ack", 32'(exit_ack), 32'(m_ack));
    chk("fail", 32'(exit_fail), 32'(m_fail));
    chk("gate", 32'(gate_open), 32'(m_open));
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic takes(input int k);
    entry_take = 1'b1;
    repeat (k) tick();
    entry_take = 1'b0;
  endtask
  initial begin
    int cnt;
    logic seen;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_therm", 32'(avail_therm), 32'hFF);
    chk("rst_count", 32'(avail_count), 32'd8);
    chk("rst_pulses", {29'd0, guest_full, exit_ack, exit_fail}, 32'd0);
    takes(3);
    chk("t2_therm", 32'(avail_therm), 32'h1F);
    exit_req = 1'b1;
    tick();
    chk("t2_gate", 32'(gate_open), 32'd1);
    tick();
    tick();
    vehicle_pass = 1'b1;
    tick();
    vehicle_pass = 1'b0;
    exit_req = 1'b0;
    chk("t2_ack", {30'd0, exit_ack, gate_open}, 32'h2);
    chk("t2_therm2", 32'(avail_therm), 32'h3F);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exit_req = 1'b1;
    tick();
    exit_req = 1'b0;
    chk("t3_fail", {30'd0, exit_fail, gate_open}, 32'h2);
    chk("t3_therm", 32'(avail_therm), 32'hFF);
    tick();
    chk("t3_gate", 32'(gate_open), 32'd0);
    takes(1);
    exit_req = 1'b1;
    cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (gate_open) cnt++;
      seen = exit_fail;
    end
    exit_req = 1'b0;
    chk("t4_open_cycles", 32'(cnt), 32'd16);
    chk("t4_fail", 32'(seen), 32'd1);
    chk("t4_therm", 32'(avail_therm), 32'h7F);
    tick();
    takes(3);
    chk("t5_therm", 32'(avail_therm), 32'h0F);
    exit_req = 1'b1;
    tick();
    vehicle_pass = 1'b1;
    entry_take = 1'b1;
    tick();
    vehicle_pass = 1'b0;
    entry_take = 1'b0;
    exit_req = 1'b0;
    chk("t5_same", 32'(avail_therm), 32'h0F);
    chk("t5_ack", 32'(exit_ack), 32'd1);
    takes(4);
    chk("t5_full", {23'd0, guest_full, avail_therm}, 32'h100);
    takes(1);
    chk("t5_under", {23'd0, guest_full, avail_therm}, 32'h100);
    exit_req = 1'b1;
    tick();
    chk("t6_open", 32'(gate_open), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exit_req = 1'b0;
    chk("t6_gate", 32'(gate_open), 32'd0);
    chk("t6_therm", 32'(avail_therm), 32'hFF);
    exit_req = 1'b1;
    tick();
    exit_req = 1'b0;
    chk("t6_idle", 32'(exit_fail), 32'd1);
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      if (rst || (exit_req && (m_ack || m_fail))) exit_req = 1'b0;
      else if (!exit_req && m_idle) exit_req = ($urandom_range(0, 3) == 0);
      vehicle_pass = ($urandom_range(0, 5) == 0);
      entry_take = ($urandom_range(0, 3) == 0);
    end
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
